// File: rtl/edge_window_fetch.sv
// edge_window_fetch
//   Producer side of the edge-detection pixel interface. For each centre
//   coordinate requested by the edge stage it reads the 8 neighbours from
//   the greyscale frame-buffer BRAM and presents the 3x3 window together
//   with a one-cycle edgeValid pulse and an echo of the coordinate.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   enable               greyscale frame available; gates the start of a fetch
//   inX, inY             requested centre (screen coordinates)
//   rdAddress            BRAM port-B address (registered)
//   rdPixel              BRAM port-B data, valid one cycle after rdAddress
//   ul..dr               window pixels (registered, held until next VALID)
//   edgeValid            one-cycle pulse: window and coordinate echo valid
//   outX_edgeOut/outY_edgeOut  centre coordinate belonging to the window
//
// States
//   IDLE  | wait for enable, latch centre, issue neighbour 0
//   FETCH | k = 0..7 address on the bus, issue neighbour k+1
//   DRAIN | capture dr, load the output window
//   VALID | edgeValid high for one cycle
module edge_window_fetch #(
  parameter int COL_BIAS   = 20,
  parameter int ROW_BIAS   = 40,
  parameter int ROW_LENGTH = 600,
  parameter int COL_LENGTH = 400,
  parameter int ADDR_W     = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [9:0]        inX,
  input  logic [8:0]        inY,
  output logic [ADDR_W-1:0] rdAddress,
  input  logic [3:0]        rdPixel,
  output logic [3:0]        ul,
  output logic [3:0]        uc,
  output logic [3:0]        ur,
  output logic [3:0]        ml,
  output logic [3:0]        mr,
  output logic [3:0]        dl,
  output logic [3:0]        dc,
  output logic [3:0]        dr,
  output logic              edgeValid,
  output logic [9:0]        outX_edgeOut,
  output logic [8:0]        outY_edgeOut
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

  state_t      state;
  logic [2:0]  k;
  logic [9:0]  cx;
  logic [8:0]  cy;

  // Two-stage tag pipeline following the BRAM: iss* travels with rdAddress,
  // cap* lines up with rdPixel one cycle later.
  logic        issValid, capValid;
  logic [2:0]  issIdx, capIdx;
  logic        issOor, capOor;
  logic [3:0]  stage [8];

  logic [9:0]        srcX;
  logic [8:0]        srcY;
  logic [2:0]        nextIdx;
  int                nx, ny;
  logic              nextOor;
  logic [ADDR_W-1:0] nextAddr;
  logic [3:0]        sample;

  // Neighbour address for the next issue. In IDLE the centre comes straight
  // from the inputs so neighbour 0 goes out on the same edge that latches it.
  always_comb begin
    srcX    = (state == IDLE) ? inX : cx;
    srcY    = (state == IDLE) ? inY : cy;
    nextIdx = (state == IDLE) ? 3'd0 : k + 3'd1;
    // int arithmetic keeps 0-1 negative instead of wrapping into range
    nx = int'(srcX);
    ny = int'(srcY);
    case (nextIdx)
      3'd0, 3'd3, 3'd5: nx = nx - 1;
      3'd2, 3'd4, 3'd7: nx = nx + 1;
      default: ;
    endcase
    case (nextIdx)
      3'd0, 3'd1, 3'd2: ny = ny - 1;
      3'd5, 3'd6, 3'd7: ny = ny + 1;
      default: ;
    endcase
    nextOor = !((nx >= COL_BIAS) && (nx <= COL_BIAS + ROW_LENGTH - 1) &&
                (ny >= ROW_BIAS) && (ny <= ROW_BIAS + COL_LENGTH - 1));
    nextAddr = nextOor ? '0
             : ADDR_W'((nx - COL_BIAS) + (ny - ROW_BIAS) * ROW_LENGTH);
    sample = capOor ? 4'd0 : rdPixel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      cx           <= '0;
      cy           <= '0;
      rdAddress    <= '0;
      issValid     <= 1'b0;
      issIdx       <= '0;
      issOor       <= 1'b0;
      capValid     <= 1'b0;
      capIdx       <= '0;
      capOor       <= 1'b0;
      for (int i = 0; i < 8; i++) stage[i] <= '0;
      ul <= '0; uc <= '0; ur <= '0; ml <= '0;
      mr <= '0; dl <= '0; dc <= '0; dr <= '0;
      edgeValid    <= 1'b0;
      outX_edgeOut <= '0;
      outY_edgeOut <= '0;
    end else begin
      edgeValid <= 1'b0;
      issValid  <= 1'b0;
      capValid  <= issValid;
      capIdx    <= issIdx;
      capOor    <= issOor;
      if (capValid) stage[capIdx] <= sample;

      case (state)
        IDLE: begin
          if (enable) begin
            cx        <= inX;
            cy        <= inY;
            k         <= '0;
            rdAddress <= nextAddr;
            issValid  <= 1'b1;
            issIdx    <= nextIdx;
            issOor    <= nextOor;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (k == 3'd7) begin
            state <= DRAIN;
          end else begin
            k         <= k + 3'd1;
            rdAddress <= nextAddr;
            issValid  <= 1'b1;
            issIdx    <= nextIdx;
            issOor    <= nextOor;
          end
        end
        DRAIN: begin
          // dr arrives this cycle, so it bypasses the staging array
          ul           <= stage[0];
          uc           <= stage[1];
          ur           <= stage[2];
          ml           <= stage[3];
          mr           <= stage[4];
          dl           <= stage[5];
          dc           <= stage[6];
          dr           <= sample;
          outX_edgeOut <= cx;
          outY_edgeOut <= cy;
          edgeValid    <= 1'b1;
          state        <= VALID;
        end
        VALID:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
